// File: rtl/rns_barrett_reduce_pipe_pkg.sv
// Shared limb types, RNS moduli for the q / B / Ba bases and their Barrett constants.
package rns_barrett_reduce_pipe_pkg;

  localparam int LIMB_W      = 32;
  localparam int Q_BASIS_LEN = 2;
  localparam int N_SLOTS_DEF = 8;

  typedef logic [LIMB_W-1:0]   limb_t;
  typedef logic [2*LIMB_W-1:0] wide_t;
  typedef logic [LIMB_W:0]     mu_t;
  typedef logic [LIMB_W+1:0]   rem_t;
  typedef logic [2*LIMB_W+1:0] prod_t;

  typedef enum logic [1:0] {
    BASIS_Q  = 2'd0,
    BASIS_B  = 2'd1,
    BASIS_BA = 2'd2
  } basis_e;

  // Every modulus lies in (2^(W-1), 2^W) so the Barrett shifts by W-1 / W+1 stay valid.
  localparam limb_t Q_BASIS  [Q_BASIS_LEN] = '{32'hFFFF_FFFB, 32'h8000_0001};
  localparam limb_t B_BASIS  [Q_BASIS_LEN] = '{32'hFFFF_FFC5, 32'hC000_0001};
  localparam limb_t BA_BASIS [Q_BASIS_LEN] = '{32'hFFFF_FF2F, 32'hA000_0001};

  // mu = floor(2^(2W) / q), fits in W+1 bits because q > 2^(W-1).
  function automatic mu_t barrett_mu(input limb_t q);
    prod_t num;
    prod_t den;
    num = prod_t'(1) << (2 * LIMB_W);
    den = prod_t'(q);
    return mu_t'(num / den);
  endfunction

  localparam mu_t BARRETT_MU_Q  [Q_BASIS_LEN] = '{barrett_mu(Q_BASIS[0]),  barrett_mu(Q_BASIS[1])};
  localparam mu_t BARRETT_MU_B  [Q_BASIS_LEN] = '{barrett_mu(B_BASIS[0]),  barrett_mu(B_BASIS[1])};
  localparam mu_t BARRETT_MU_BA [Q_BASIS_LEN] = '{barrett_mu(BA_BASIS[0]), barrett_mu(BA_BASIS[1])};

  function automatic limb_t basis_mod(input basis_e sel, input int j);
    case (sel)
      BASIS_B:  return B_BASIS[j];
      BASIS_BA: return BA_BASIS[j];
      default:  return Q_BASIS[j];
    endcase
  endfunction

  function automatic mu_t basis_mu(input basis_e sel, input int j);
    case (sel)
      BASIS_B:  return BARRETT_MU_B[j];
      BASIS_BA: return BARRETT_MU_BA[j];
      default:  return BARRETT_MU_Q[j];
    endcase
  endfunction

  function automatic rem_t cond_sub(input rem_t r, input limb_t q);
    return (r >= rem_t'(q)) ? (r - rem_t'(q)) : r;
  endfunction

endpackage

// File: rtl/rns_barrett_reduce_pipe_if.sv
// Streaming bus of the reducer: product slots in, reduced slots out, frame error flag.
interface rns_barrett_reduce_pipe_if
  import rns_barrett_reduce_pipe_pkg::*;
#(
  parameter int LIMBS = Q_BASIS_LEN,
  parameter int W     = LIMB_W
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LIMBS*2*W-1:0]   in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LIMBS*W-1:0]     out_data;
  logic                   out_last;
  logic                   frame_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_err
  );
endinterface

// File: rtl/rns_barrett_reduce_pipe_lane.sv
// One Barrett reduction lane for a fixed modulus; three registers sharing the pipeline enable.
module rns_barrett_reduce_pipe_lane
  import rns_barrett_reduce_pipe_pkg::*;
#(
  parameter limb_t Q  = Q_BASIS[0],
  parameter mu_t   MU = BARRETT_MU_Q[0]
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  wide_t x,
  output limb_t r
);

  mu_t  qh_s1;
  rem_t xl_s1;
  rem_t r_s2;

  // S1 estimates the quotient, S2 forms the partial remainder (< 3q), S3 folds it into [0,q).
  // Only the low W+2 bits of x survive S1: the true remainder fits there, so the upper bits cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      qh_s1 <= '0;
      xl_s1 <= '0;
      r_s2  <= '0;
      r     <= '0;
    end else if (en) begin
      qh_s1 <= mu_t'((prod_t'(x[2*LIMB_W-1:LIMB_W-1]) * prod_t'(MU)) >> (LIMB_W + 1));
      xl_s1 <= x[LIMB_W+1:0];
      r_s2  <= xl_s1 - rem_t'(rem_t'(qh_s1) * rem_t'(Q));
      r     <= limb_t'(cond_sub(cond_sub(r_s2, Q), Q));
    end
  end

endmodule

// File: rtl/rns_barrett_reduce_pipe.sv
// Pipelined per-limb Barrett reducer with valid/ready streaming and frame slot tracking.
module rns_barrett_reduce_pipe
  import rns_barrett_reduce_pipe_pkg::*;
#(
  parameter int     LIMBS   = Q_BASIS_LEN,
  parameter int     W       = LIMB_W,
  parameter int     N_SLOTS = N_SLOTS_DEF,
  parameter basis_e BASIS   = BASIS_Q
) (
  input logic clk,
  input logic reset,
  rns_barrett_reduce_pipe_if.slave bus
);

  localparam int CW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N_SLOTS - 1);

  logic          en;
  logic          acc;
  logic          emit;
  logic          v1, v2, v3;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          ferr;
  limb_t         lane_out [LIMBS];

  // Whole pipe advances together; a stalled output slot freezes every stage behind it.
  assign en            = !v3 || bus.out_ready;
  assign acc           = bus.in_valid && en;
  assign emit          = v3 && bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3;
  assign bus.out_last  = v3 && (out_cnt == CNT_MAX);
  assign bus.frame_err = ferr;

  for (genvar j = 0; j < LIMBS; j++) begin : g_lane
    rns_barrett_reduce_pipe_lane #(
      .Q  (basis_mod(BASIS, j)),
      .MU (basis_mu(BASIS, j))
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .x     (bus.in_data[j*2*W +: 2*W]),
      .r     (lane_out[j])
    );
  end

  // Pack lane results onto the output bus.
  always_comb begin
    bus.out_data = '0;
    for (int j = 0; j < LIMBS; j++) begin
      bus.out_data[j*W +: W] = lane_out[j];
    end
  end

  // Stage valids shift with the shared enable; bubbles travel as valid=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Input and output slot counters run independently; frame_err latches any in_last disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      ferr    <= 1'b0;
    end else begin
      if (acc) begin
        in_cnt <= (in_cnt == CNT_MAX) ? '0 : in_cnt + CW'(1);
        if (bus.in_last != (in_cnt == CNT_MAX)) begin
          ferr <= 1'b1;
        end
      end
      if (emit) begin
        out_cnt <= (out_cnt == CNT_MAX) ? '0 : out_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rns_barrett_reduce_pipe.sv
// Scoreboard bench: x = a*q + b with b < q, so each expected residue is b by construction.
module tb_rns_barrett_reduce_pipe;

  localparam int LIMBS   = 2;
  localparam int W       = 32;
  localparam int N_SLOTS = 8;
  localparam logic [31:0] Q0 = 32'hFFFF_FFFB;
  localparam logic [31:0] Q1 = 32'h8000_0001;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          cyc;
    logic        chk;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   idx;
  exp_t exp_q[$];

  rns_barrett_reduce_pipe_if #(.LIMBS(LIMBS), .W(W)) bus ();

  rns_barrett_reduce_pipe #(.LIMBS(LIMBS), .W(W), .N_SLOTS(N_SLOTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mkx(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    return 64'(a) * 64'(q) + 64'(b);
  endfunction

  // Must be entered just after a rising edge; returns just after the accepting edge.
  task automatic send_slot(input logic [127:0] xd, input logic [63:0] ed, input logic bad_last,
                           input logic chk);
    logic last_exp;
    last_exp     = (idx == N_SLOTS - 1);
    bus.in_valid = 1'b1;
    bus.in_data  = xd;
    bus.in_last  = bad_last ? 1'b1 : last_exp;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back('{data: ed, last: last_exp, cyc: cyc, chk: chk});
        idx = (idx == N_SLOTS - 1) ? 0 : idx + 1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        return;
      end
    end
    check("accept_timeout", 64'd1, 64'd0);
    bus.in_valid = 1'b0;
  endtask

  task automatic pattern_slot(input int p, input logic bad_last, input logic chk);
    logic [127:0] xd;
    logic [63:0]  ed;
    logic [31:0]  q, a, b;
    for (int l = 0; l < LIMBS; l++) begin
      q = (l == 0) ? Q0 : Q1;
      case ((p + 3 * l) % 8)
        0:       begin a = q - 32'd2; b = 32'd1;         end
        1:       begin a = 32'd0;     b = 32'd0;         end
        2:       begin a = 32'd1;     b = 32'd0;         end
        3:       begin a = q - 32'd1; b = 32'd0;         end
        4:       begin a = 32'd5;     b = 32'd7;         end
        5:       begin a = q - 32'd1; b = q - 32'd1;     end
        6:       begin a = 32'd0;     b = q - 32'd1;     end
        default: begin a = q >> 1;    b = 32'd123456789; end
      endcase
      xd[l*64 +: 64] = mkx(a, b, q);
      ed[l*32 +: 32] = b;
    end
    send_slot(xd, ed, bad_last, chk);
  endtask

  task automatic random_slot(input logic chk);
    logic [127:0] xd;
    logic [63:0]  ed;
    logic [31:0]  q, a, b;
    for (int l = 0; l < LIMBS; l++) begin
      q = (l == 0) ? Q0 : Q1;
      a = $urandom % q;
      b = $urandom % q;
      xd[l*64 +: 64] = mkx(a, b, q);
      ed[l*32 +: 32] = b;
    end
    send_slot(xd, ed, 1'b0, chk);
  endtask

  // Asserts reset immediately (caller is just past a rising edge) and drops all expectations.
  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    exp_q.delete();
    idx = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every output transfer, checks stall stability in between.
  initial begin
    exp_t        e;
    logic        have_prev;
    logic [63:0] prev_data;
    logic        prev_last;
    have_prev = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid) begin
        if (have_prev) begin
          check("stall_data_frozen", bus.out_data, prev_data);
          check("stall_last_frozen", 64'(bus.out_last), 64'(prev_last));
        end
        if (bus.out_ready) begin
          have_prev = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_last", 64'(bus.out_last), 64'(e.last));
            if (e.chk) check("latency", 64'(cyc - e.cyc), 64'd3);
          end
        end else begin
          check("in_ready_stall", 64'(bus.in_ready), 64'd0);
          prev_data = bus.out_data;
          prev_last = bus.out_last;
          have_prev = 1'b1;
        end
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cyc           = 0;
    n_cmp         = 0;
    n_bad         = 0;
    idx           = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_frame_err", 64'(bus.frame_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Boundary residues, back to back with fixed 3-cycle latency.
    for (int p = 0; p < 8; p++) pattern_slot(p, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) random_slot(1'b1);

    // Two full frames with correct in_last.
    for (int i = 0; i < 2 * N_SLOTS; i++) pattern_slot(i, 1'b0, 1'b1);
    drain();
    check("frame_err_clean", 64'(bus.frame_err), 64'd0);

    // Output stalled for 5 cycles with the pipe full.
    fork
      begin
        for (int i = 0; i < 12; i++) pattern_slot(i + 2, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // in_last on slot 3 of a fresh frame.
    do_reset();
    for (int i = 0; i < 3; i++) pattern_slot(i, 1'b0, 1'b1);
    check("frame_err_pre", 64'(bus.frame_err), 64'd0);
    pattern_slot(3, 1'b1, 1'b1);
    check("frame_err_set", 64'(bus.frame_err), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("frame_err_sticky", 64'(bus.frame_err), 64'd1);
    drain();

    // Reset with three slots in flight.
    for (int i = 0; i < 3; i++) pattern_slot(i + 4, 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    check("rst6_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst6_out_last", 64'(bus.out_last), 64'd0);
    check("rst6_frame_err", 64'(bus.frame_err), 64'd0);
    check("rst6_out_data", bus.out_data, 64'd0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < N_SLOTS; i++) pattern_slot(i + 1, 1'b0, 1'b1);
    drain();
    check("frame_err_after_rst", 64'(bus.frame_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
